// File: rtl/mem_stage_dual_arbiter_if.sv
// Data-memory port bundle shared by the MEM-stage arbiter (master) and the
// single-ported data memory (slave).
interface mem_stage_dual_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_we;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_addr,
        output dmem_we,
        output dmem_wdata,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wdata,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_dual_arbiter.sv
// MEM stage for the dual-issue pipeline: serializes same-cycle memory accesses
// of both lanes over one shared data-memory port and registers MEM/WB state.
module mem_stage_dual_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        MemReadEn_inst1_Mem,
    input  logic        MemWriteEn_inst1_Mem,
    input  logic        RegWriteEn_inst1_Mem,
    input  logic [1:0]  MemtoReg_inst1_Mem,
    input  logic [31:0] AluOutMem_inst1,
    input  logic [31:0] ReadData2Mem_inst1,
    input  logic [4:0]  dest_reg_inst1_Mem,
    input  logic [7:0]  pcPlus1_Mem,

    input  logic        MemReadEn_inst2_Mem,
    input  logic        MemWriteEn_inst2_Mem,
    input  logic        RegWriteEn_inst2_Mem,
    input  logic [1:0]  MemtoReg_inst2_Mem,
    input  logic [31:0] AluOutMem_inst2,
    input  logic [31:0] ReadData2Mem_inst2,
    input  logic [4:0]  dest_reg_inst2_Mem,
    input  logic [7:0]  pcPlus2_Mem,

    mem_stage_dual_arbiter_if.master dmem,

    output logic        stall_mem,

    output logic        RegWriteEn_inst1_WB,
    output logic [1:0]  MemtoReg_inst1_WB,
    output logic [31:0] AluOut_inst1_WB,
    output logic [31:0] MemData_inst1_WB,
    output logic [4:0]  dest_reg_inst1_WB,
    output logic [7:0]  pcPlus_inst1_WB,

    output logic        RegWriteEn_inst2_WB,
    output logic [1:0]  MemtoReg_inst2_WB,
    output logic [31:0] AluOut_inst2_WB,
    output logic [31:0] MemData_inst2_WB,
    output logic [4:0]  dest_reg_inst2_WB,
    output logic [7:0]  pcPlus_inst2_WB
);

    typedef enum logic {
        SERVE  = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state;

    logic              acc1, acc2, dual;
    logic [ADDR_W-1:0] port_addr;
    logic              port_we;
    logic [31:0]       port_wdata;
    logic [31:0]       rdata;

    logic              hold_rw1;
    logic [1:0]        hold_m2r1;
    logic [31:0]       hold_alu1;
    logic [4:0]        hold_dest1;
    logic [7:0]        hold_pc1;
    logic [31:0]       hold_data1;

    assign acc1  = MemReadEn_inst1_Mem | MemWriteEn_inst1_Mem;
    assign acc2  = MemReadEn_inst2_Mem | MemWriteEn_inst2_Mem;
    assign dual  = (state == SERVE) & acc1 & acc2;
    assign rdata = dmem.dmem_rdata;

    // Gating with reset keeps the port quiet during reset, so a lane-2 store
    // caught by reset in SECOND is dropped instead of written.
    assign stall_mem = reset & dual;

    always_comb begin
        port_addr  = '0;
        port_we    = 1'b0;
        port_wdata = '0;
        if (reset) begin
            if ((state == SECOND) || (!acc1 && acc2)) begin
                port_addr  = AluOutMem_inst2[ADDR_W-1:0];
                port_we    = MemWriteEn_inst2_Mem;
                port_wdata = ReadData2Mem_inst2;
            end else if (acc1) begin
                port_addr  = AluOutMem_inst1[ADDR_W-1:0];
                port_we    = MemWriteEn_inst1_Mem;
                port_wdata = ReadData2Mem_inst1;
            end
        end
    end

    assign dmem.dmem_addr  = port_addr;
    assign dmem.dmem_we    = port_we;
    assign dmem.dmem_wdata = port_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= SERVE;
            hold_rw1            <= 1'b0;
            hold_m2r1           <= '0;
            hold_alu1           <= '0;
            hold_dest1          <= '0;
            hold_pc1            <= '0;
            hold_data1          <= '0;
            RegWriteEn_inst1_WB <= 1'b0;
            MemtoReg_inst1_WB   <= '0;
            AluOut_inst1_WB     <= '0;
            MemData_inst1_WB    <= '0;
            dest_reg_inst1_WB   <= '0;
            pcPlus_inst1_WB     <= '0;
            RegWriteEn_inst2_WB <= 1'b0;
            MemtoReg_inst2_WB   <= '0;
            AluOut_inst2_WB     <= '0;
            MemData_inst2_WB    <= '0;
            dest_reg_inst2_WB   <= '0;
            pcPlus_inst2_WB     <= '0;
        end else begin
            case (state)
                SERVE: begin
                    if (acc1 && acc2) begin
                        // Park lane 1's result; both WB slots carry a bubble this cycle.
                        hold_rw1            <= RegWriteEn_inst1_Mem;
                        hold_m2r1           <= MemtoReg_inst1_Mem;
                        hold_alu1           <= AluOutMem_inst1;
                        hold_dest1          <= dest_reg_inst1_Mem;
                        hold_pc1            <= pcPlus1_Mem;
                        hold_data1          <= MemReadEn_inst1_Mem ? rdata : 32'd0;
                        RegWriteEn_inst1_WB <= 1'b0;
                        MemtoReg_inst1_WB   <= '0;
                        AluOut_inst1_WB     <= '0;
                        MemData_inst1_WB    <= '0;
                        dest_reg_inst1_WB   <= '0;
                        pcPlus_inst1_WB     <= '0;
                        RegWriteEn_inst2_WB <= 1'b0;
                        MemtoReg_inst2_WB   <= '0;
                        AluOut_inst2_WB     <= '0;
                        MemData_inst2_WB    <= '0;
                        dest_reg_inst2_WB   <= '0;
                        pcPlus_inst2_WB     <= '0;
                        state               <= SECOND;
                    end else begin
                        RegWriteEn_inst1_WB <= RegWriteEn_inst1_Mem;
                        MemtoReg_inst1_WB   <= MemtoReg_inst1_Mem;
                        AluOut_inst1_WB     <= AluOutMem_inst1;
                        MemData_inst1_WB    <= MemReadEn_inst1_Mem ? rdata : 32'd0;
                        dest_reg_inst1_WB   <= dest_reg_inst1_Mem;
                        pcPlus_inst1_WB     <= pcPlus1_Mem;
                        RegWriteEn_inst2_WB <= RegWriteEn_inst2_Mem;
                        MemtoReg_inst2_WB   <= MemtoReg_inst2_Mem;
                        AluOut_inst2_WB     <= AluOutMem_inst2;
                        MemData_inst2_WB    <= MemReadEn_inst2_Mem ? rdata : 32'd0;
                        dest_reg_inst2_WB   <= dest_reg_inst2_Mem;
                        pcPlus_inst2_WB     <= pcPlus2_Mem;
                    end
                end
                SECOND: begin
                    RegWriteEn_inst1_WB <= hold_rw1;
                    MemtoReg_inst1_WB   <= hold_m2r1;
                    AluOut_inst1_WB     <= hold_alu1;
                    MemData_inst1_WB    <= hold_data1;
                    dest_reg_inst1_WB   <= hold_dest1;
                    pcPlus_inst1_WB     <= hold_pc1;
                    RegWriteEn_inst2_WB <= RegWriteEn_inst2_Mem;
                    MemtoReg_inst2_WB   <= MemtoReg_inst2_Mem;
                    AluOut_inst2_WB     <= AluOutMem_inst2;
                    MemData_inst2_WB    <= MemReadEn_inst2_Mem ? rdata : 32'd0;
                    dest_reg_inst2_WB   <= dest_reg_inst2_Mem;
                    pcPlus_inst2_WB     <= pcPlus2_Mem;
                    state               <= SERVE;
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule
